// File: rtl/td4_pkg.sv
// td4_pkg: shared opcodes, PC width and sequencer state encoding for the TD4 sequencer
package td4_pkg;
  localparam int PC_W = 4;
  localparam logic [3:0] OP_JMP = 4'b1111;
  localparam logic [3:0] OP_JNC = 4'b1110;
  typedef enum logic [1:0] {
    SEQ_HALT = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_STEP = 2'b10
  } seq_state_e;
endpackage

// File: rtl/td4_sequencer_rise_detect.sv
// rise_detect: one-cycle pulse on a rising level; history resets to RST_VAL so a level held through reset does not fire
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);
  logic prev_q;
  // remember last cycle's level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= RST_VAL;
    else prev_q <= sig_i;
  assign rise_o = sig_i & ~prev_q;
endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: run/halt/step and breakpoint control for the TD4 PC; `TD4_SEQ_RETIRE_CNT_EN builds the retired-instruction counter
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit RESET_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       instr,
  input  logic [PC_W-1:0]  pc_addr,
  input  logic             alu_carry,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic [PC_W-1:0]  pc_in,
  output logic             pc_load_n,
  output logic             exec_en,
  output logic             carry_flag,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retire_cnt
);
  seq_state_e state_q, state_d;
  logic carry_q, carry_d;
  logic bp_hit_q, bp_hit_d;
  logic bp_skip_q, bp_skip_d;
  logic run_rise, step_rise, bp_stop, exec, jump;

  rise_detect #(.RST_VAL(1'b1)) u_run_rise (
    .clk(clk), .rst_n(rst_n), .sig_i(run_req), .rise_o(run_rise)
  );
  rise_detect #(.RST_VAL(1'b1)) u_step_rise (
    .clk(clk), .rst_n(rst_n), .sig_i(step_req), .rise_o(step_rise)
  );

  assign bp_stop = bp_en && (pc_addr == bp_addr) && !bp_skip_q;
  // rst_n gating makes exec_en drop the moment reset asserts, whatever the reset state
  assign exec = rst_n && ((state_q == SEQ_RUN && !halt_req && !bp_stop) || state_q == SEQ_STEP);
  assign jump = (instr[7:4] == OP_JMP) || (instr[7:4] == OP_JNC && !carry_q);
  // holding is a reload of the current address; jumps load the immediate
  assign pc_load_n  = exec && !jump;
  assign pc_in      = exec ? instr[3:0] : pc_addr;
  assign exec_en    = exec;
  assign carry_flag = carry_q;
  assign halted     = (state_q == SEQ_HALT);
  assign bp_hit     = bp_hit_q;

  // control state, carry flag and breakpoint bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RESET_RUN ? SEQ_RUN : SEQ_HALT;
      carry_q   <= 1'b0;
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      bp_hit_q  <= bp_hit_d;
      bp_skip_q <= bp_skip_d;
    end

  // next state; resuming arms bp_skip so the breakpoint instruction itself executes once
  always_comb begin
    state_d   = state_q;
    bp_hit_d  = bp_hit_q;
    bp_skip_d = exec ? 1'b0 : bp_skip_q;
    carry_d   = exec ? alu_carry : carry_q;
    case (state_q)
      SEQ_HALT:
        if (!halt_req && (run_rise || step_rise)) begin
          state_d   = run_rise ? SEQ_RUN : SEQ_STEP;
          bp_hit_d  = 1'b0;
          bp_skip_d = 1'b1;
        end
      SEQ_RUN: begin
        state_d  = (halt_req || bp_stop) ? SEQ_HALT : SEQ_RUN;
        bp_hit_d = bp_hit_q || bp_stop;
      end
      SEQ_STEP: state_d = SEQ_HALT;
      default:  state_d = SEQ_HALT;
    endcase
  end

`ifdef TD4_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  // count executed instructions, wrapping naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (exec) cnt_q <= cnt_q + CNT_W'(1);
  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif
endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Run/halt/step controller for the 4-bit program counter of the TD4 core.
- Decodes jump opcodes and the carry flag, and drives the PC's active-low load and its load value.
- Gates register-file/output commits with exec_en, and supports single-step and one hardware breakpoint.
- Sits between instruction ROM output, ALU carry-out and the PC; the PC itself is unchanged. Holding is done by reloading the current address.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- RESET_RUN, 0, 1 = leave reset in RUN; 0 = leave reset in HALT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  8  current instruction; [7:4] opcode, [3:0] immediate.
- pc_addr  input  4  PC output (current fetch address).
- alu_carry  input  1  ALU carry-out of the current instruction.
- run_req  input  1  level; rising edge requests RUN.
- step_req  input  1  level; rising edge requests one instruction.
- halt_req  input  1  level; high forces HALT.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  4  breakpoint address.
- pc_in  output  4  PC load value.
- pc_load_n  output  1  PC load, active low (0 = load pc_in, 1 = increment).
- exec_en  output  1  commit enable for registers/output port this cycle.
- carry_flag  output  1  registered carry flag.
- halted  output  1  state == HALT.
- bp_hit  output  1  sticky; set on breakpoint stop.
- retire_cnt  output  CNT_W  instructions executed.

Behaviour:
- Interface:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset values: state = RUN if RESET_RUN else HALT; carry_flag = 0; bp_hit = 0; retire_cnt = 0; bp_skip = 0.
  - The run/step edge-detector history registers reset to 1, so inputs held high across reset never trigger.
- States: HALT, RUN, STEP (2-bit encoding from the package).
- Combinational outputs, zero latency, same cycle:
  - exec = (state == RUN && !halt_req && !bp_stop) || state == STEP.
  - bp_stop = bp_en && pc_addr == bp_addr && !bp_skip.
  - exec_en = exec.
  - When !exec: pc_load_n = 0 and pc_in = pc_addr, so the PC holds.
  - When exec and (opcode == 4'b1111, JMP) or (opcode == 4'b1110, JNC, and carry_flag == 0): pc_load_n = 0 and pc_in = instr[3:0].
  - When exec otherwise: pc_load_n = 1 (increment); pc_in = instr[3:0] (don't-care).
- Sequential effects on a clock edge with exec = 1: carry_flag <= alu_carry and retire_cnt <= retire_cnt + 1, wrapping at 2^CNT_W.
- JNC uses carry_flag from the previous executed instruction.
- Transitions:
  - HALT -> RUN on run_req rise. HALT -> STEP on step_req rise. If both rise in the same cycle, RUN wins. halt_req high blocks both (stay in HALT).
  - RUN -> HALT when halt_req, or when bp_stop (also sets bp_hit). The instruction at the breakpoint address is not executed.
  - STEP -> HALT unconditionally after one cycle. The breakpoint is ignored in STEP.
- Breakpoint skip and clear:
  - On any HALT -> RUN or HALT -> STEP transition, bp_hit clears and bp_skip sets.
  - bp_skip clears after the first executed cycle, so resuming from a breakpoint executes that instruction.
- PC wrap 15 -> 0 needs no special handling. The sequencer never stalls fetch.
- Reset asserted mid-RUN: outputs go immediately to the reset values; exec_en deasserts asynchronously.

Optional Feature:
- Macro TD4_SEQ_RETIRE_CNT_EN.
- Defined: retire_cnt counts as specified.
- Undefined: the counter register is not built and retire_cnt is tied to 0. The port remains present.

Decomposition:
- Package td4_pkg:
  - opcode constants OP_JMP = 4'b1111, OP_JNC = 4'b1110;
  - state encoding SEQ_HALT / SEQ_RUN / SEQ_STEP;
  - PC_W = 4.
- Sub-module rise_detect (registered previous value with reset-to-1 parameter, pulse output), instantiated for run_req and step_req.

Test Plan:
1. RESET_RUN = 0, reset release, pulse step_req three times with instr = 8'h00 -> exec_en high exactly 3 cycles, pc_load_n = 1 each time, retire_cnt = 3, halted returns 1.
2. RUN, instr = 8'hF5 at pc_addr = 2 -> same cycle pc_load_n = 0, pc_in = 5. With carry_flag = 1, instr = 8'hE9 -> pc_load_n = 1; with carry_flag = 0 -> pc_in = 9, pc_load_n = 0.
3. bp_en = 1, bp_addr = 6, RUN from 0 with sequential code -> halts with pc_addr = 6, bp_hit = 1, exec_en = 0. run_req rise -> address 6 executes, next stop at 6 only after wrap.
4. HALT with pc_addr = 4 for 10 cycles -> pc_load_n = 0, pc_in = 4 every cycle, carry_flag and retire_cnt unchanged.
5. run_req and step_req rise together with halt_req = 0 -> RUN. Repeated with halt_req = 1 -> stays HALT.
6. Assert rst_n low mid-RUN between edges -> exec_en, carry_flag, bp_hit, retire_cnt go to 0 immediately. run_req held high through release -> no RUN until it drops and rises again.
